// File: rtl/calc_alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/logic ops, plus multi-cycle shift-add MUL and restoring DIV.
// Results and flags are registered and change only when the FSM enters DONE.
module calc_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_lo_q, result_lo_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 load;
  logic [WIDTH-1:0]     new_lo, new_hi;
  logic                 new_carry, new_err;
  logic [WIDTH:0]       add_sum, sub_diff;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    load        = 1'b0;
    new_lo      = '0;
    new_hi      = '0;
    new_carry   = 1'b0;
    new_err     = 1'b0;

    accept   = ena && start && (state_q != RUN);
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = {1'b0, a} - {1'b0, b};

    // acc holds {partial product, remaining multiplier} for MUL, {remainder, quotient} for DIV
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
    div_next  = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    step_next = (op_q == OP_MUL) ? mul_next : div_next;

    if (ena) begin
      case (state_q)
        RUN: begin
          acc_d = step_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d   = DONE;
            cnt_d     = '0;
            load      = 1'b1;
            new_lo    = step_next[WIDTH-1:0];
            new_hi    = step_next[2*WIDTH-1:WIDTH];
            new_carry = (op_q == OP_MUL) && (step_next[2*WIDTH-1:WIDTH] != '0);
          end
        end
        default: begin
          state_d = IDLE;
          if (accept) begin
            op_d  = op;
            cnt_d = '0;
            case (op)
              OP_ADD: begin
                state_d = DONE; load = 1'b1;
                new_lo = add_sum[WIDTH-1:0]; new_carry = add_sum[WIDTH];
              end
              OP_SUB: begin
                state_d = DONE; load = 1'b1;
                new_lo = sub_diff[WIDTH-1:0]; new_carry = sub_diff[WIDTH];
              end
              OP_AND: begin state_d = DONE; load = 1'b1; new_lo = a & b; end
              OP_OR:  begin state_d = DONE; load = 1'b1; new_lo = a | b; end
              OP_XOR: begin state_d = DONE; load = 1'b1; new_lo = a ^ b; end
              OP_MUL: begin
                state_d = RUN;
                opa_d   = a;
                acc_d   = {{WIDTH{1'b0}}, b};
              end
              OP_DIV: begin
                if (b == '0) begin
                  state_d = DONE; load = 1'b1;
                  new_lo = '1; new_hi = a; new_err = 1'b1;
                end else begin
                  state_d = RUN;
                  opb_d   = b;
                  acc_d   = {{WIDTH{1'b0}}, a};
                end
              end
              default: begin state_d = DONE; load = 1'b1; new_err = 1'b1; end
            endcase
          end
        end
      endcase
    end

    if (load) begin
      result_lo_d = new_lo;
      result_hi_d = new_hi;
      carry_d     = new_carry;
      err_d       = new_err;
      zero_d      = (new_lo == '0) && (new_hi == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq (WIDTH=8): latency, results, flags, stall, ignore and reset cases.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_calc_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry, zero, err;
  logic [W-1:0] result_lo, result_hi;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, busy_n, done_n;

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .carry(carry), .zero(zero), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns 1ns after its accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat0 = edges since accept, counting the accept edge as 1.
  task automatic wait_done(input int lat0, output int l, output int bn);
    l = lat0; bn = 0;
    while (!done && l < 64) begin
      if (busy) bn++;
      tick();
      l++;
    end
    if (!done) check("done_timeout", 32'(done), 1);
  endtask

  task automatic check_res(input string tag, input int lo, input int hi,
                           input int c, input int z, input int e);
    check({tag, "_lo"}, 32'(result_lo), lo);
    check({tag, "_hi"}, 32'(result_hi), hi);
    check({tag, "_carry"}, 32'(carry), c);
    check({tag, "_zero"}, 32'(zero), z);
    check({tag, "_err"}, 32'(err), e);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_res("rst", 0, 0, 0, 1, 0);

    // ADD 200+100
    issue(3'd0, 8'd200, 8'd100);
    wait_done(1, lat, busy_n);
    check("add_lat", lat, 1);
    check_res("add", 'h2C, 0, 1, 0, 0);
    tick();
    check("add_done_pulse", 32'(done), 0);
    check("add_hold_lo", 32'(result_lo), 'h2C);

    // SUB 3-5 then back-to-back SUB 5-5 accepted from DONE
    issue(3'd1, 8'd3, 8'd5);
    check("sub_lat", 32'(done), 1);
    check_res("sub_borrow", 'hFE, 0, 1, 0, 0);
    issue(3'd1, 8'd5, 8'd5);
    check("sub_b2b_done", 32'(done), 1);
    check_res("sub_zero", 0, 0, 0, 1, 0);
    tick();

    // logic ops
    issue(3'd2, 8'hF0, 8'h3C);
    check_res("and", 'h30, 0, 0, 0, 0);
    issue(3'd3, 8'hF0, 8'h3C);
    check_res("or", 'hFC, 0, 0, 0, 0);
    issue(3'd4, 8'hF0, 8'h3C);
    check_res("xor", 'hCC, 0, 0, 0, 0);
    tick();

    // MUL 0xFF*0xFF
    issue(3'd5, 8'hFF, 8'hFF);
    wait_done(1, lat, busy_n);
    check("mul_lat", lat, 9);
    check("mul_busy_cycles", busy_n, 8);
    check_res("mul", 'h01, 'hFE, 1, 0, 0);
    tick();
    check("mul_done_pulse", 32'(done), 0);

    // DIV 100/7
    issue(3'd6, 8'd100, 8'd7);
    wait_done(1, lat, busy_n);
    check("div_lat", lat, 9);
    check_res("div", 14, 2, 0, 0, 0);
    tick();

    // DIV by zero
    issue(3'd6, 8'd5, 8'd0);
    wait_done(1, lat, busy_n);
    check("div0_lat", lat, 1);
    check_res("div0", 'hFF, 5, 0, 0, 1);
    tick();

    // reserved op
    issue(3'd7, 8'd5, 8'd3);
    wait_done(1, lat, busy_n);
    check("op7_lat", lat, 1);
    check_res("op7", 0, 0, 0, 1, 1);
    tick();

    // MUL 3*4 with an ADD request during RUN cycle 3
    issue(3'd5, 8'd3, 8'd4);
    tick(); tick(); tick();
    op = 3'd0; a = 8'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, lat, busy_n);
    check("ign_lat", lat, 9);
    check_res("ign", 12, 0, 0, 0, 0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_n++;
    end
    check("ign_extra_done", done_n, 0);

    // ena stall mid-MUL: 13*11 = 143
    issue(3'd5, 8'd13, 8'd11);
    tick(); tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ena = 1'b1;
    wait_done(8, lat, busy_n);
    check("stall_lat", lat, 14);
    check_res("stall", 'h8F, 0, 0, 0, 0);

    // ena low while in DONE; a start during the stall is ignored
    ena = 1'b0;
    op = 3'd0; a = 8'd1; b = 8'd1; start = 1'b1;
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_n++;
    end
    start = 1'b0;
    check("stall_done_held", done_n, 3);
    check("stall_start_ignored", 32'(result_lo), 'h8F);
    ena = 1'b1;
    tick();
    check("stall_done_release", 32'(done), 0);

    // reset at RUN cycle 4 of MUL
    issue(3'd5, 8'hFF, 8'hFF);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstrun_busy", 32'(busy), 0);
    check("rstrun_done", 32'(done), 0);
    check_res("rstrun", 0, 0, 0, 1, 0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) done_n++;
    end
    check("rstrun_no_done", done_n, 0);
    issue(3'd0, 8'd2, 8'd2);
    wait_done(1, lat, busy_n);
    check("post_rst_lat", lat, 1);
    check_res("post_rst_add", 4, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_alu_seq.md
CALC_ALU_SEQ -- requirements
Module: calc_alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1, global enable; when low, all state holds.
REQ-005 The block SHALL have port start, input, 1, the operation request strobe.
REQ-006 The block SHALL have port op, input, 3, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 reserved.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, unsigned operands.
REQ-008 The block SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-010 The block SHALL have ports result_lo and result_hi, output, WIDTH each, the result pair.
REQ-011 The block SHALL have ports carry, zero and err, output, 1 each, the status flags.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-013 A request SHALL be accepted on an edge with ena=1, start=1 and state IDLE or DONE (back-to-back allowed); op, a and b are latched on that edge.
REQ-014 start while in RUN SHALL be ignored, with no effect on state, operands or outputs.
REQ-015 ADD/SUB/AND/OR/XOR SHALL go IDLE->DONE on accept (latency 1: done high in the cycle after the accept edge), with result_hi=0.
REQ-016 ADD SHALL give result_lo=(a+b) mod 2^WIDTH, carry=carry-out; SUB SHALL give result_lo=(a-b) mod 2^WIDTH, carry=borrow (a<b); logic ops SHALL give carry=0.
REQ-017 MUL SHALL be shift-add: RUN for exactly WIDTH cycles, then DONE (done WIDTH+1 cycles after accept), with {result_hi,result_lo}=a*b over 2*WIDTH bits and carry = (result_hi!=0).
REQ-018 DIV with b!=0 SHALL be restoring division: RUN for WIDTH cycles, then DONE, with result_lo=a/b, result_hi=a%b, carry=0.
REQ-019 DIV with b==0 SHALL skip RUN and go to DONE with latency 1, err=1, result_lo=all ones, result_hi=a.
REQ-020 op 7 SHALL go to DONE with latency 1, err=1 and results 0.
REQ-021 err SHALL be 0 for all other completions.
REQ-022 zero SHALL equal (result_lo==0 && result_hi==0) and SHALL be updated together with the results.
REQ-023 result_lo, result_hi, carry, zero and err SHALL change only on entry to DONE and SHALL hold until the next DONE; intermediate RUN values SHALL NOT be visible on the outputs.
REQ-024 The RUN cycle counter SHALL count 0..WIDTH-1 and SHALL leave RUN exactly when it reaches WIDTH-1; there is no wrap-around.
REQ-025 DONE SHALL last one enabled cycle, then return to IDLE, or re-enter RUN/DONE if a new request is accepted on that edge.
REQ-026 ena=0 SHALL freeze the state, counter, datapath and outputs; done stays high for the whole stall if state is DONE.
REQ-027 start SHALL be ignored while ena=0.

Reset
REQ-028 rst_n=0 sampled on an edge SHALL force state IDLE, counter 0, busy=0, done=0, result_lo=0, result_hi=0, carry=0, zero=1, err=0, regardless of ena.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse; the first request after reset release behaves normally.

Verification (WIDTH=8)
REQ-030 ADD a=200, b=100 -> done one cycle after accept, result_lo=0x2C, result_hi=0, carry=1, zero=0; SUB 3-5 -> result_lo=0xFE, carry=1; SUB 5-5 -> zero=1.
REQ-031 MUL 0xFF*0xFF -> busy high exactly 8 cycles, done 9 cycles after accept, result_hi=0xFE, result_lo=0x01, carry=1.
REQ-032 DIV 100/7 -> result_lo=14, result_hi=2, latency 9; DIV 5/0 -> latency 1, err=1, result_lo=0xFF, result_hi=5; op=7 -> err=1, zero=1.
REQ-033 Start MUL 3*4, pulse start with ADD 1+1 at RUN cycle 3 -> second request ignored, result 12, exactly one done pulse.
REQ-034 Drop ena for 5 cycles mid-MUL -> done delayed by exactly 5 cycles, product correct; ena=0 during DONE -> done held high.
REQ-035 Assert rst_n=0 at RUN cycle 4 of MUL -> next cycle busy=0, done=0, results 0, zero=1, no done pulse; a following ADD 2+2 -> result_lo=4.
